// File: rtl/ps2_keymatrix.sv
// PS/2 scancode to CHIP-8 16-key matrix decoder with an optional press/release event FIFO.
// Define PS2_KEYMATRIX_EVENT_FIFO_EN to build the event FIFO; otherwise the evt_* outputs are tied to 0.
module ps2_keymatrix #(
    parameter int LAYOUT      = 0,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        kbd_ready,
    input  logic [7:0]  kbd_data,
    output logic [15:0] key_matrix,
    output logic        key_any,
    output logic        evt_valid,
    output logic [3:0]  evt_key,
    output logic        evt_down,
    input  logic        evt_pop,
    input  logic        evt_clear,
    output logic        evt_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } state_t;

    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;
    localparam logic [7:0] CODE_BAT = 8'hAA;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   byte_stb;
    logic [7:0]             byte_q;
    logic                   ready_rise;
    logic                   byte_accept;

    assign ready_rise = sync_q[SYNC_STAGES-1] & ~last_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync_q   <= '0;
            last_q   <= 1'b0;
            byte_stb <= 1'b0;
            byte_q   <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], kbd_ready};
            last_q   <= sync_q[SYNC_STAGES-1];
            byte_stb <= ready_rise;
            if (ready_rise) begin
                byte_q <= kbd_data;
            end
        end
    end

    // A strobe is only decoded if kbd_ready was still high one sample later,
    // so pulses shorter than SYNC_STAGES+1 cycles are rejected.
    assign byte_accept = byte_stb & sync_q[0];

    // Returns {mapped, key}.
    function automatic logic [4:0] map_code(input logic [7:0] code);
        logic [4:0] r;
        r = '0;
        if (LAYOUT == 0) begin
            case (code)
                8'h16: r = {1'b1, 4'h1};
                8'h1E: r = {1'b1, 4'h2};
                8'h26: r = {1'b1, 4'h3};
                8'h25: r = {1'b1, 4'hC};
                8'h15: r = {1'b1, 4'h4};
                8'h1D: r = {1'b1, 4'h5};
                8'h24: r = {1'b1, 4'h6};
                8'h2D: r = {1'b1, 4'hD};
                8'h1C: r = {1'b1, 4'h7};
                8'h1B: r = {1'b1, 4'h8};
                8'h23: r = {1'b1, 4'h9};
                8'h2B: r = {1'b1, 4'hE};
                8'h1A: r = {1'b1, 4'hA};
                8'h22: r = {1'b1, 4'h0};
                8'h21: r = {1'b1, 4'hB};
                8'h2A: r = {1'b1, 4'hF};
                default: r = '0;
            endcase
        end else begin
            case (code)
                8'h45: r = {1'b1, 4'h0};
                8'h16: r = {1'b1, 4'h1};
                8'h1E: r = {1'b1, 4'h2};
                8'h26: r = {1'b1, 4'h3};
                8'h25: r = {1'b1, 4'h4};
                8'h2E: r = {1'b1, 4'h5};
                8'h36: r = {1'b1, 4'h6};
                8'h3D: r = {1'b1, 4'h7};
                8'h3E: r = {1'b1, 4'h8};
                8'h46: r = {1'b1, 4'h9};
                8'h1C: r = {1'b1, 4'hA};
                8'h32: r = {1'b1, 4'hB};
                8'h21: r = {1'b1, 4'hC};
                8'h23: r = {1'b1, 4'hD};
                8'h24: r = {1'b1, 4'hE};
                8'h2B: r = {1'b1, 4'hF};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    state_t state;
    state_t state_next;
    logic   do_make;
    logic   do_break;
    logic   do_bat;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        if (byte_accept) begin
            unique case (state)
                ST_IDLE: begin
                    if (byte_q == CODE_BRK)      state_next = ST_BRK;
                    else if (byte_q == CODE_EXT) state_next = ST_EXT;
                    else                         state_next = ST_IDLE;
                end
                ST_BRK:     state_next = ST_IDLE;
                ST_EXT:     state_next = (byte_q == CODE_BRK) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        do_make  = 1'b0;
        do_break = 1'b0;
        do_bat   = 1'b0;
        if (byte_accept) begin
            case (state)
                ST_IDLE: begin
                    if (byte_q == CODE_BAT) begin
                        do_bat = 1'b1;
                    end else if (byte_q != CODE_BRK && byte_q != CODE_EXT) begin
                        do_make = 1'b1;
                    end
                end
                ST_BRK:  do_break = 1'b1;
                default: ;
            endcase
        end
    end

    logic [4:0] code_map;
    logic       hit_mapped;
    logic [3:0] hit_key;
    logic       push_req;

    assign code_map   = map_code(byte_q);
    assign hit_mapped = code_map[4];
    assign hit_key    = code_map[3:0];
    // Typematic repeats and breaks of released keys change nothing and emit nothing.
    assign push_req   = hit_mapped & ((do_make & ~key_matrix[hit_key]) |
                                      (do_break & key_matrix[hit_key]));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            key_matrix <= '0;
        end else if (do_bat) begin
            key_matrix <= '0;
        end else if (push_req) begin
            key_matrix[hit_key] <= do_make;
        end
    end

    assign key_any = |key_matrix;

`ifdef PS2_KEYMATRIX_EVENT_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [4:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop_take;
    logic        push_take;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_take   = evt_pop & ~fifo_empty;
    assign push_take  = push_req & (~fifo_full | pop_take);

    // NOTE: the event memory is reset so evt_key/evt_down read 0 out of reset.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_overflow <= 1'b0;
        end else if (evt_clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            evt_overflow <= 1'b0;
        end else begin
            if (pop_take) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_take) begin
                mem[wr_ptr[AW-1:0]] <= {hit_key, do_make};
                wr_ptr              <= wr_ptr + PTR_ONE;
            end else if (push_req) begin
                evt_overflow <= 1'b1;
            end
        end
    end

    assign evt_valid = ~fifo_empty;
    assign evt_key   = mem[rd_ptr[AW-1:0]][4:1];
    assign evt_down  = mem[rd_ptr[AW-1:0]][0];
`else
    logic fifo_unused;
    assign fifo_unused  = ^{evt_pop, evt_clear};
    assign evt_valid    = 1'b0;
    assign evt_key      = '0;
    assign evt_down     = 1'b0;
    assign evt_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keymatrix.sv
// Self-checking bench for ps2_keymatrix: directed test-plan sequences plus randomized byte streams,
// compared every cycle against a transaction-level model of the matrix and event queue.
module tb_ps2_keymatrix;

    localparam int LAYOUT = 0;
    localparam int SYNC   = 2;
    localparam int DEPTH  = 4;
`ifdef PS2_KEYMATRIX_EVENT_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic        clk;
    logic        res;
    logic        kbd_ready;
    logic [7:0]  kbd_data;
    logic [15:0] key_matrix;
    logic        key_any;
    logic        evt_valid;
    logic [3:0]  evt_key;
    logic        evt_down;
    logic        evt_pop;
    logic        evt_clear;
    logic        evt_overflow;

    ps2_keymatrix #(
        .LAYOUT(LAYOUT),
        .SYNC_STAGES(SYNC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .res(res),
        .kbd_ready(kbd_ready),
        .kbd_data(kbd_data),
        .key_matrix(key_matrix),
        .key_any(key_any),
        .evt_valid(evt_valid),
        .evt_key(evt_key),
        .evt_down(evt_down),
        .evt_pop(evt_pop),
        .evt_clear(evt_clear),
        .evt_overflow(evt_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scancode of each key index, per layout.
    byte unsigned tbl [2][16] = '{
        '{8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
          8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A},
        '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
          8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B}
    };

    function automatic int key_of(input logic [7:0] b);
        for (int k = 0; k < 16; k++) begin
            if (tbl[LAYOUT][k] == b) return k;
        end
        return -1;
    endfunction

    typedef struct {
        int key;
        bit down;
    } ev_t;

    // Model state: prefix flags, held keys, event queue, overflow flag, run of high ready samples.
    logic [15:0] m_matrix = '0;
    bit          m_brk    = 1'b0;
    bit          m_ext    = 1'b0;
    bit          m_ovf    = 1'b0;
    int          run      = 0;
    ev_t         q[$];
    bit          m_push;
    ev_t         m_ev;
    bit          m_pop;

    task automatic model_byte(input logic [7:0] b, output bit push, output ev_t ev);
        int k;
        push = 1'b0;
        ev   = '{0, 1'b0};
        k    = key_of(b);
        if (m_ext) begin
            if (!m_brk && b == 8'hF0) m_brk = 1'b1;
            else begin
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end else if (m_brk) begin
            m_brk = 1'b0;
            if (k >= 0 && m_matrix[k]) begin
                m_matrix[k] = 1'b0;
                push = 1'b1;
                ev = '{k, 1'b0};
            end
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hAA) begin
            m_matrix = '0;
        end else if (k >= 0 && !m_matrix[k]) begin
            m_matrix[k] = 1'b1;
            push = 1'b1;
            ev = '{k, 1'b1};
        end
    endtask

    // A byte is decoded once kbd_ready has been sampled high on SYNC+1 consecutive edges.
    always @(posedge clk or posedge res) begin
        if (res) begin
            m_matrix = '0;
            m_brk    = 1'b0;
            m_ext    = 1'b0;
            m_ovf    = 1'b0;
            run      = 0;
            q.delete();
        end else begin
            m_push = 1'b0;
            if (run == SYNC + 1) model_byte(kbd_data, m_push, m_ev);
            run   = kbd_ready ? run + 1 : 0;
            m_pop = evt_pop && (q.size() > 0);
            if (evt_clear) begin
                q.delete();
                m_ovf = 1'b0;
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) begin
                    if (q.size() < DEPTH) q.push_back(m_ev);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en && !res) begin
            check("matrix", key_matrix, m_matrix);
            check("key_any", key_any, m_matrix != 0);
            check("evt_valid", evt_valid, FIFO_EN && q.size() > 0);
            check("evt_overflow", evt_overflow, FIFO_EN && m_ovf);
            if (FIFO_EN && q.size() > 0) begin
                check("evt_key", evt_key, q[0].key);
                check("evt_down", evt_down, q[0].down);
            end
        end
    end

    bit rnd = 1'b0;

    task automatic step();
        @(negedge clk);
        if (rnd) begin
            evt_pop   = ($urandom_range(0, 11) == 0);
            evt_clear = ($urandom_range(0, 199) == 0);
        end else begin
            evt_pop   = 1'b0;
            evt_clear = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi = SYNC + 3, input int lo = 3);
        kbd_data  = b;
        kbd_ready = 1'b1;
        repeat (hi) step();
        kbd_ready = 1'b0;
        repeat (lo) step();
    endtask

    // Asserts evt_pop exactly on the edge where the byte is decoded.
    task automatic send_byte_pop(input logic [7:0] b);
        kbd_data  = b;
        kbd_ready = 1'b1;
        repeat (SYNC + 1) step();
        evt_pop = 1'b1;
        step();
        repeat (2) step();
        kbd_ready = 1'b0;
        repeat (3) step();
    endtask

    task automatic pop_once();
        evt_pop = 1'b1;
        step();
    endtask

    task automatic clear_once();
        evt_clear = 1'b1;
        step();
    endtask

    task automatic check_head(input string name, input int key, input bit down);
        check({name, "_valid"}, evt_valid, FIFO_EN);
        check({name, "_key"}, evt_key, FIFO_EN ? key : 0);
        check({name, "_down"}, evt_down, FIFO_EN ? down : 1'b0);
    endtask

    int exp_keys [4] = '{2, 3, 12, 4};

    initial begin
        res       = 1'b1;
        kbd_ready = 1'b0;
        kbd_data  = '0;
        evt_pop   = 1'b0;
        evt_clear = 1'b0;
        repeat (3) @(negedge clk);
        res    = 1'b0;
        cmp_en = 1'b1;
        step();
        check("rst_matrix", key_matrix, 16'h0000);
        check("rst_any", key_any, 1'b0);
        check("rst_valid", evt_valid, 1'b0);
        check("rst_key", evt_key, 4'h0);
        check("rst_down", evt_down, 1'b0);
        check("rst_ovf", evt_overflow, 1'b0);

        // Make then break of key 5.
        send_byte(8'h1D);
        check("tp1_make", key_matrix, 16'h0020);
        check_head("tp1_ev0", 5, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h1D);
        check("tp1_break", key_matrix, 16'h0000);
        pop_once();
        check_head("tp1_ev1", 5, 1'b0);
        pop_once();
        check("tp1_empty", evt_valid, 1'b0);

        // Typematic repeat emits one event only.
        repeat (3) send_byte(8'h1D);
        check("tp2_matrix", key_matrix, 16'h0020);
        check_head("tp2_ev", 5, 1'b1);
        pop_once();
        check("tp2_single", evt_valid, 1'b0);
        send_byte(8'hAA);
        check("tp2_bat", key_matrix, 16'h0000);

        // Extended sequences never reach the matrix.
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'h16);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        check("tp3_matrix", key_matrix, 16'h0002);
        check_head("tp3_ev", 1, 1'b1);
        pop_once();
        check("tp3_single", evt_valid, 1'b0);
        send_byte(8'h1D);
        check("tp3_idle", key_matrix, 16'h0022);
        clear_once();
        send_byte(8'hAA);

        // Five makes into a four-entry queue.
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        check("tp4_full_noovf", evt_overflow, 1'b0);
        send_byte(8'h15);
        check("tp4_ovf", evt_overflow, FIFO_EN);
        check("tp4_matrix", key_matrix, 16'h101E);
        clear_once();
        check("tp4_clr_valid", evt_valid, 1'b0);
        check("tp4_clr_ovf", evt_overflow, 1'b0);

        // Push and pop on the same edge while full.
        send_byte(8'hAA);
        send_byte(8'h16);
        send_byte(8'h1E);
        send_byte(8'h26);
        send_byte(8'h25);
        send_byte_pop(8'h15);
        check("tp5_ovf", evt_overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("tp5_drain%0d", i), exp_keys[i], 1'b1);
            pop_once();
        end
        check("tp5_empty", evt_valid, 1'b0);

        // Reset in the break state: the next byte is a make.
        send_byte(8'hAA);
        send_byte(8'hF0);
        #2 res = 1'b1;
        #4 res = 1'b0;
        step();
        check("tp6_rst", key_matrix, 16'h0000);
        send_byte(8'h1D);
        check("tp6_make", key_matrix, 16'h0020);
        check_head("tp6_ev", 5, 1'b1);

        // Too-short ready pulse is not decoded.
        clear_once();
        send_byte(8'hAA);
        send_byte(8'h16, 2, 3);
        check("tp7_short", key_matrix, 16'h0000);
        check("tp7_noev", evt_valid, 1'b0);
        send_byte(8'h16);
        check("tp7_long", key_matrix, 16'h0002);

        // Randomized byte stream with random pop/clear.
        rnd = 1'b1;
        for (int n = 0; n < 500; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 19);
            if (r < 4)       b = 8'hF0;
            else if (r < 6)  b = 8'hE0;
            else if (r == 6) b = 8'hAA;
            else if (r == 7) b = 8'($urandom);
            else             b = tbl[LAYOUT][$urandom_range(0, 15)];
            send_byte(b, ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(SYNC + 1, 6),
                      $urandom_range(2, 4));
        end
        rnd = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
